split_vector_driver: RTL
========================

Name: split_vector_driver

Overview:
- Streaming front/back end for a split constraint checker (one `split_N`-style combinational block with many wide `var_*` inputs and a 1-bit `x` output).
- Deserialises an assignment frame from a word stream into one flat vector that drives the checker's concatenated `var_*` inputs.
- Waits a fixed settle time, samples `x`, and returns a per-frame result over a valid/ready handshake.
- Keeps running counts of evaluated and satisfying assignments.

Parameters:
- TOTAL_BITS, 1536: width of the flat vector, equal to the sum of the checker's `var_*` widths.
- WORD_W, 32: stream word width.
- CHK_LAT, 2: cycles between vector update and `x` sampling (settle/pipeline allowance). Legal range 1..15.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- s_data  in  WORD_W  assignment word
- s_last  in  1  marks the final word of a frame
- vec  out  TOTAL_BITS  flat assignment to the checker; bit 0 = `var_0[0]`, packed in ascending var index
- chk_x  in  1  checker result `x`
- r_valid  out  1  result valid
- r_ready  in  1  result consumed when r_valid & r_ready
- r_sat  out  1  sampled chk_x for the frame
- r_err  out  1  frame length error
- eval_cnt  out  CNT_W  frames evaluated
- sat_cnt  out  CNT_W  frames with r_sat=1
- busy  out  1  high in any state other than LOAD with word index 0

Behaviour:
- Reset:
  - Everything resets asynchronously: vec=0, s_ready=0 (goes to 1 on the first clock edge after reset release), r_valid=0, r_sat=0, r_err=0, eval_cnt=0, sat_cnt=0, busy=0, state=LOAD, word index=0.
  - Reset asserted mid-frame discards the partial frame and any pending result. Counters are cleared.
- NWORDS = ceil(TOTAL_BITS/WORD_W).
- State LOAD:
  - s_ready=1.
  - Accepted word k writes `vec[k*WORD_W +: WORD_W]`. Bits beyond TOTAL_BITS in the last word are dropped.
  - Bits of vec not yet written in the current frame keep their values from the previous frame until written.
  - Accepted word with s_last=1 and k==NWORDS-1: go to EVAL, err=0.
  - s_last=1 with k<NWORDS-1 (short frame): zero vec bits above the last written word in the same edge, set err=1, go to EVAL.
  - Word k==NWORDS-1 with s_last=0 (long frame): go to DRAIN, err=1.
- State DRAIN:
  - s_ready=1. Accepted words are discarded and vec is unchanged.
  - The accepted word with s_last=1 moves to EVAL.
- State EVAL:
  - s_ready=0.
  - A settle counter loads CHK_LAT on entry and decrements each cycle.
  - When it reaches 0: capture r_sat=chk_x and r_err=err, go to RESULT.
  - Latency: the last accepted word at edge t gives r_valid=1 after edge t+CHK_LAT+1.
- State RESULT:
  - r_valid=1, s_ready=0. r_sat and r_err are held stable while r_valid & !r_ready.
  - On the handshake edge: eval_cnt+=1; sat_cnt+=1 if r_sat; r_valid=0; go to LOAD with index 0.
  - Errored frames still count in eval_cnt and in sat_cnt if r_sat.
- Counters saturate at all-ones and do not wrap.
- Back-to-back frames: s_ready rises in the cycle after the result handshake. No input is accepted while a result is pending.
- vec is held constant in EVAL and RESULT, so chk_x is stable at sampling.
- s_data/s_last are ignored when s_valid=0. r_ready is ignored when r_valid=0.

Test Plan:
- Reset release, TOTAL_BITS=1536, WORD_W=32: send 48 words of 0xFFFFFFFF with s_last on word 47, chk_x tied 1 -> vec all ones; r_valid after CHK_LAT+1 cycles; r_sat=1, r_err=0; after r_ready, eval_cnt=1, sat_cnt=1.
- Short frame: 3 words 0x1,0x2,0x3 with s_last on word 2, following a prior all-ones frame -> vec[95:0]=0x000000030000000200000001, vec[1535:96]=0, r_err=1.
- Long frame: 50 words with s_last on word 49 -> words 48-49 dropped, vec = first 48 words, r_err=1.
- Back-pressure: hold r_ready=0 for 10 cycles while toggling chk_x -> s_ready=0, r_sat frozen at its sampled value, counters unchanged until the handshake.
- Saturation: CNT_W=4, 17 satisfying frames -> eval_cnt=sat_cnt=15.
- Reset asserted at word 20 of a frame -> all outputs zero immediately; the next complete frame evaluates normally with eval_cnt=1.

Source files
------------

// File: rtl/split_vector_driver.sv
// split_vector_driver
// Streaming front/back end for a wide combinational split constraint checker.
// Words arriving on the s_* stream are packed into the flat vector that feeds
// the checker's concatenated var_* inputs. After a fixed settle time the
// checker output is sampled and returned on the r_* handshake. Running counts
// of evaluated and satisfying frames are kept and saturate at all-ones.

`default_nettype none

module split_vector_driver #(
    parameter int TOTAL_BITS = 1536,
    parameter int WORD_W     = 32,
    parameter int CHK_LAT    = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_last,
    output logic [TOTAL_BITS-1:0] vec,
    input  logic                  chk_x,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  r_sat,
    output logic                  r_err,
    output logic [CNT_W-1:0]      eval_cnt,
    output logic [CNT_W-1:0]      sat_cnt,
    output logic                  busy
);

    localparam int NWORDS = (TOTAL_BITS + WORD_W - 1) / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int LAT_W  = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CHK_LAT);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        EVAL   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        word_idx;
    logic [LAT_W-1:0]        settle_cnt;
    logic                    err_flag;
    logic                    accept;
    logic [TOTAL_BITS-1:0]   vec_next;

    assign accept = s_valid & s_ready;

    // Vector after accepting the current word: the addressed word slice takes
    // s_data (bits past TOTAL_BITS simply have no home), and a frame that ends
    // early clears every slice above the one just written.
    always_comb begin
        vec_next = vec;
        for (int b = 0; b < TOTAL_BITS; b++) begin
            if ((b / WORD_W) == int'(word_idx)) begin
                vec_next[b] = s_data[b % WORD_W];
            end else if (s_last && ((b / WORD_W) > int'(word_idx))) begin
                vec_next[b] = 1'b0;
            end
        end
    end

    // Frame sequencer with all handshake, result and statistic outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            word_idx   <= '0;
            settle_cnt <= '0;
            err_flag   <= 1'b0;
            vec        <= '0;
            s_ready    <= 1'b0;
            r_valid    <= 1'b0;
            r_sat      <= 1'b0;
            r_err      <= 1'b0;
            eval_cnt   <= '0;
            sat_cnt    <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        vec  <= vec_next;
                        busy <= 1'b1;
                        if (s_last) begin
                            err_flag   <= (word_idx != LAST_IDX);
                            word_idx   <= '0;
                            settle_cnt <= LAT_LOAD;
                            s_ready    <= 1'b0;
                            state      <= EVAL;
                        end else if (word_idx == LAST_IDX) begin
                            err_flag <= 1'b1;
                            state    <= DRAIN;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (accept && s_last) begin
                        word_idx   <= '0;
                        settle_cnt <= LAT_LOAD;
                        s_ready    <= 1'b0;
                        state      <= EVAL;
                    end
                end

                EVAL: begin
                    if (settle_cnt == '0) begin
                        r_sat   <= chk_x;
                        r_err   <= err_flag;
                        r_valid <= 1'b1;
                        state   <= RESULT;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                RESULT: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        if (eval_cnt != '1) begin
                            eval_cnt <= eval_cnt + 1'b1;
                        end
                        if (r_sat && (sat_cnt != '1)) begin
                            sat_cnt <= sat_cnt + 1'b1;
                        end
                        word_idx <= '0;
                        s_ready  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= LOAD;
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
